// File: rtl/imem_sync.sv
// Synchronous instruction memory for the sMIPS fetch stage. It has a registered fetch,
// a valid/stall handshake, alignment and range error flags, a loader write port and a post-reset NOP clear.
module imem_sync #(
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          DEPTH_LOG2 = 6,
    parameter logic [31:0]          BASE_ADDR  = 32'h0000_0000,
    parameter logic [DATA_W-1:0]    NOP_WORD   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_req,
    input  logic [31:0]             addr,
    input  logic                    stall,
    output logic [DATA_W-1:0]       inst,
    output logic                    inst_valid,
    output logic                    err_align,
    output logic                    err_range,
    output logic                    ready,
    input  logic                    ld_we,
    input  logic [DEPTH_LOG2-1:0]   ld_addr,
    input  logic [DATA_W-1:0]       ld_data,
    output logic                    o_dbg_state
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DEPTH_LOG2-1:0]   r_clr_idx;
    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic [DATA_W-1:0]       r_inst;
    logic                    r_valid;
    logic                    r_err_align;
    logic                    r_err_range;

    logic [31:0]             w_offset;
    logic                    w_in_range;
    logic                    w_misalign;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_hold;
    logic                    w_accept;
    logic [DATA_W-1:0]       w_rd_data;

    // Handshake: a response stays on inst while stall=1 and inst_valid=1. A fetch is
    // accepted in RUN whenever fetch_req=1 and the output is not held that way.
    assign w_offset   = addr - BASE_ADDR;
    assign w_in_range = {1'b0, w_offset} < SPAN;
    assign w_misalign = addr[1:0] != 2'b00;
    assign w_idx      = w_offset[DEPTH_LOG2+1:2];
    assign w_hold     = stall && r_valid;
    assign w_accept   = (r_state == S_RUN) && fetch_req && !w_hold;
    // Write-first: a same-cycle load to the fetched word is forwarded.
    assign w_rd_data  = (ld_we && (ld_addr == w_idx)) ? ld_data : r_mem[w_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (&r_clr_idx) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    // The array has no reset: the clear sequence owns its contents after every reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clr_idx] <= NOP_WORD;
            end else if (ld_we) begin
                r_mem[ld_addr] <= ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst      <= NOP_WORD;
            r_valid     <= 1'b0;
            r_err_align <= 1'b0;
            r_err_range <= 1'b0;
        end else if (!w_hold) begin
            if (w_accept) begin
                r_valid     <= 1'b1;
                r_err_align <= w_misalign;
                r_err_range <= !w_in_range;
                r_inst      <= (w_misalign || !w_in_range) ? NOP_WORD : w_rd_data;
            end else begin
                r_valid     <= 1'b0;
                r_err_align <= 1'b0;
                r_err_range <= 1'b0;
            end
        end
    end

    assign inst        = r_inst;
    assign inst_valid  = r_valid;
    assign err_align   = r_err_align;
    assign err_range   = r_err_range;
    assign ready       = (r_state == S_RUN);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync. A driver updates a word-array model at each edge and queues the expected responses.
// A negedge monitor pops each response and compares it with the DUT output.
module tb_imem_sync;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst, fetch_req, stall, ld_we;
    logic [31:0] addr, ld_data, inst;
    logic [5:0]  ld_addr;
    logic        inst_valid, err_align, err_range, ready, dbg_state;

    logic        b_rst, b_fetch_req, b_ld_we;
    logic [31:0] b_addr, b_ld_data, b_inst;
    logic [5:0]  b_ld_addr;
    logic        b_valid, b_err_align, b_err_range, b_ready, b_dbg_state;

    always #5 clk = ~clk;

    imem_sync #(.DATA_W(32), .DEPTH_LOG2(6), .BASE_ADDR(32'h0), .NOP_WORD(32'h0)) u_dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .addr(addr), .stall(stall),
        .inst(inst), .inst_valid(inst_valid), .err_align(err_align), .err_range(err_range),
        .ready(ready), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .o_dbg_state(dbg_state)
    );

    imem_sync #(.DATA_W(32), .DEPTH_LOG2(6), .BASE_ADDR(32'h400), .NOP_WORD(32'h0)) u_dut_b (
        .clk(clk), .rst(b_rst), .fetch_req(b_fetch_req), .addr(b_addr), .stall(1'b0),
        .inst(b_inst), .inst_valid(b_valid), .err_align(b_err_align), .err_range(b_err_range),
        .ready(b_ready), .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
        .o_dbg_state(b_dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Reference model: the word array, the readiness and clear count, the output-valid state and the last instruction.
    logic [31:0] m_mem [DEPTH];
    logic        m_run   = 1'b0;
    int          m_cnt   = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_last  = 32'h0;
    logic [33:0] exp_q [$];
    logic [33:0] b_q [$];

    task automatic model_edge(input logic fr, input logic [31:0] a, input logic st,
                              input logic we, input logic [5:0] la, input logic [31:0] ld,
                              input logic r);
        logic [31:0] off;
        logic        ea, er, hold;
        logic [31:0] d;
        if (r) begin
            m_run = 1'b0; m_cnt = 0; m_valid = 1'b0; m_last = 32'h0;
        end else if (!m_run) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_run = 1'b1;
                foreach (m_mem[k]) m_mem[k] = 32'h0;
            end
        end else begin
            hold = st && m_valid;
            off  = a - 32'h0;
            if (fr && !hold) begin
                ea = (a % 4) != 0;
                er = off >= 32'(DEPTH * 4);
                if (ea || er)                       d = 32'h0;
                else if (we && la == 6'(off / 4))   d = ld;
                else                                d = m_mem[off / 4];
                exp_q.push_back({ea, er, d});
                m_last  = d;
                m_valid = 1'b1;
            end else if (!hold) begin
                m_valid = 1'b0;
            end
            if (we) m_mem[la] = ld;
        end
    endtask

    task automatic step(input logic fr, input logic [31:0] a, input logic st,
                        input logic we, input logic [5:0] la, input logic [31:0] ld,
                        input logic r);
        fetch_req = fr; addr = a; stall = st; ld_we = we; ld_addr = la; ld_data = ld; rst = r;
        @(posedge clk);
        model_edge(fr, a, st, we, la, ld, r);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b1, a, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
    endtask

    task automatic load(input logic [5:0] la, input logic [31:0] ld);
        step(1'b0, 32'h0, 1'b0, 1'b1, la, ld, 1'b0);
    endtask

    // Release reset and count the cycles until ready rises. A stray fetch and a stray load are issued during the clear.
    task automatic count_clear(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(i == 3, 32'h20, 1'b0, i == 5, 6'd8, 32'hffff_ffff, 1'b0);
            cnt++;
            if (ready === 1'b1) break;
        end
    endtask

    logic        mon_on   = 1'b0;
    logic        hold_prev = 1'b0;
    logic [33:0] held     = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            check("ready", 64'(ready), 64'(m_run));
            check("inst_valid", 64'(inst_valid), 64'(m_valid));
            if (m_valid) begin
                if (hold_prev) begin
                    check("stall_hold", 64'({err_align, err_range, inst}), 64'(held));
                end else if (exp_q.size() == 0) begin
                    check("resp_unexpected", 64'(inst_valid), 64'd0);
                end else begin
                    held = exp_q.pop_front();
                    check("resp", 64'({err_align, err_range, inst}), 64'(held));
                end
            end else begin
                check("idle_flags", 64'({err_align, err_range}), 64'd0);
                check("idle_inst_keep", 64'(inst), 64'(m_last));
            end
            hold_prev = stall && m_valid && !rst;
        end
    end

    logic b_mon_on = 1'b0;
    always @(negedge clk) begin
        if (b_mon_on && b_valid === 1'b1) begin
            if (b_q.size() == 0) begin
                check("b_resp_unexpected", 64'(b_valid), 64'd0);
            end else begin
                check("b_resp", 64'({b_err_align, b_err_range, b_inst}), 64'(b_q.pop_front()));
            end
        end
    end

    task automatic b_step(input logic fr, input logic [31:0] a, input logic we,
                          input logic [5:0] la, input logic [31:0] ld, input logic r);
        b_fetch_req = fr; b_addr = a; b_ld_we = we; b_ld_addr = la; b_ld_data = ld; b_rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic b_fetch(input logic [31:0] a, input logic [33:0] exp);
        b_q.push_back(exp);
        b_step(1'b1, a, 1'b0, 6'd0, 32'h0, 1'b0);
        b_step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
    endtask

    int          clr_cnt;
    logic        r_fr, r_st, r_we, r_rst;
    logic [31:0] r_a, r_ld;
    logic [5:0]  r_la;
    int          r_idx, r_k;

    initial begin
        b_rst = 1'b1; b_fetch_req = 1'b0; b_addr = '0; b_ld_we = 1'b0; b_ld_addr = '0; b_ld_data = '0;
        rst = 1'b1; fetch_req = 1'b0; addr = '0; stall = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        @(posedge clk); #1;

        step(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
        check("reset_outputs", 64'({inst, inst_valid, err_align, err_range, ready}), 64'd0);
        mon_on = 1'b1;

        count_clear(clr_cnt);
        check("clear_cycles", 64'(clr_cnt), 64'd64);
        fetch(32'h20);
        idle(1);

        load(6'd0, 32'h2009_0004);
        load(6'd1, 32'h3c01_0010);
        fetch(32'h0);
        fetch(32'h4);
        idle(1);

        step(1'b1, 32'h14, 1'b0, 1'b1, 6'd5, 32'h012a_5820, 1'b0);
        idle(1);

        fetch(32'h6);
        fetch(32'h100);
        fetch(32'hffff_fffc);
        fetch(32'h103);
        idle(1);

        fetch(32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h4, 1'b1, 1'b0, 6'd0, 32'h0, 1'b0);
        fetch(32'h4);
        idle(1);

        for (int i = 0; i < 600; i++) begin
            r_fr  = $urandom_range(0, 3) != 0;
            r_k   = $urandom_range(0, 9);
            r_idx = $urandom_range(0, 63);
            if (r_k < 7)       r_a = 32'(r_idx * 4);
            else if (r_k == 7) r_a = 32'(r_idx * 4 + $urandom_range(1, 3));
            else if (r_k == 8) r_a = 32'h100 + 32'($urandom_range(0, 1023));
            else               r_a = $urandom;
            r_st  = $urandom_range(0, 3) == 0;
            r_we  = $urandom_range(0, 2) == 0;
            r_la  = ($urandom_range(0, 1) == 1) ? 6'(r_idx) : 6'($urandom_range(0, 63));
            r_ld  = $urandom;
            r_rst = $urandom_range(0, 299) == 0;
            step(r_fr, r_a, r_st, r_we, r_la, r_ld, r_rst);
        end
        idle(DEPTH + 2);

        load(6'd0, 32'h2009_0004);
        fetch(32'h0);
        step(1'b1, 32'h4, 1'b1, 1'b0, 6'd0, 32'h0, 1'b1);
        check("midrun_reset_valid", 64'({inst_valid, ready}), 64'd0);
        idle(10);
        step(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
        count_clear(clr_cnt);
        check("reclear_cycles", 64'(clr_cnt), 64'd64);
        fetch(32'h0);
        idle(2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        b_step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1);
        b_step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b1);
        b_mon_on = 1'b1;
        for (int i = 0; i < 70; i++) b_step(1'b0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0);
        check("b_ready", 64'(b_ready), 64'd1);
        b_step(1'b0, 32'h0, 1'b1, 6'd0, 32'hdead_beef, 1'b0);
        b_fetch(32'h3fc,       {1'b0, 1'b1, 32'h0});
        b_fetch(32'h400,       {1'b0, 1'b0, 32'hdead_beef});
        b_fetch(32'h4fc,       {1'b0, 1'b0, 32'h0});
        b_fetch(32'h500,       {1'b0, 1'b1, 32'h0});
        b_fetch(32'h402,       {1'b1, 1'b0, 32'h0});
        b_fetch(32'h0,         {1'b0, 1'b1, 32'h0});
        b_fetch(32'hffff_ffff, {1'b1, 1'b1, 32'h0});
        check("b_queue_drained", 64'(b_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
